// File: rtl/gcd_accel_pkg.sv
// Shared types and defaults for the subtractive GCD accelerator.
package gcd_accel_pkg;

    localparam int unsigned DEF_WIDTH    = 32;
    localparam int unsigned DEF_MAX_ITER = 65535;
    localparam int unsigned ITER_W       = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/gcd_accel.sv
// Subtractive GCD engine: one compare/subtract step per RUN cycle, with an
// iteration cap that aborts the call and flags error.
module gcd_accel
    import gcd_accel_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned MAX_ITER = DEF_MAX_ITER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  arg_a,
    input  logic [WIDTH-1:0]  arg_b,
    output logic              busy,
    output logic              finish,
    output logic [WIDTH-1:0]  return_val,
    output logic              error,
    output logic [ITER_W-1:0] iterations
);

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [ITER_W-1:0]   r_count;
    logic [ITER_W-1:0]   w_count_next;
    logic                w_terminal;
    logic                w_limit;
    logic                r_busy;
    logic                r_finish;
    logic [WIDTH-1:0]    r_result;
    logic                r_error;
    logic [ITER_W-1:0]   r_iterations;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Termination tests use the pre-step operands; the cap uses the count after this step.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count + ITER_W'(1);
        w_terminal   = (r_a == '0) || (r_b == '0) || (r_a == r_b);
        w_limit      = (w_count_next == ITER_W'(MAX_ITER));
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_terminal || w_limit) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a          <= '0;
            r_b          <= '0;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_finish     <= 1'b0;
            r_result     <= '0;
            r_error      <= 1'b0;
            r_iterations <= '0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= arg_a;
                        r_b     <= arg_b;
                        r_count <= '0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_count <= w_count_next;
                    if (w_terminal) begin
                        r_result     <= (r_a == '0) ? r_b : r_a;
                        r_error      <= 1'b0;
                        r_iterations <= w_count_next;
                        r_finish     <= 1'b1;
                    end else if (w_limit) begin
                        r_result     <= '0;
                        r_error      <= 1'b1;
                        r_iterations <= w_count_next;
                        r_finish     <= 1'b1;
                    end else if (r_a > r_b) begin
                        r_a <= r_a - r_b;
                    end else begin
                        r_b <= r_b - r_a;
                    end
                end
                S_DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        busy       = r_busy;
        finish     = r_finish;
        return_val = r_result;
        error      = r_error;
        iterations = r_iterations;
    end

endmodule
